// File: rtl/sfq_pulse_monitor.sv
// rtl/sfq_pulse_monitor.sv - toggle-encoded SFQ line monitor: sync, edge strobe, count, min-gap check
module sfq_pulse_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int GAP_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             cnt_clr,
  input  logic [GAP_W-1:0] min_gap,
  output logic             pulse_evt,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             viol,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             unknown,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    READY = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t                 cur_state;
  state_t                 nxt_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_det;
  logic                   in_unknown;
  logic [GAP_W-1:0]       gap_q;
  logic [GAP_W-1:0]       gap_nxt;
  logic [GAP_W-1:0]       gap_inc;
  logic                   cnt_inc;
  logic                   viol_set;
  logic                   gap_met;

  // X/Z on the raw line is only observable in a four-state simulator
  assign in_unknown = $isunknown(pulse_in);
  assign edge_det   = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign gap_inc    = (gap_q == '1) ? gap_q : gap_q + 1'b1;
  assign gap_met    = (gap_q >= min_gap);
  assign state      = cur_state;

  // The synchronizer is deliberately untouched by cnt_clr so a clear cannot fake an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    nxt_state = cur_state;
    gap_nxt   = gap_q;
    cnt_inc   = 1'b0;
    viol_set  = 1'b0;
    if (in_unknown) begin
      nxt_state = FAULT;
    end else begin
      case (cur_state)
        IDLE, READY: begin
          if (edge_det) begin
            cnt_inc = 1'b1;
            if (min_gap == '0) begin
              nxt_state = READY;
            end else begin
              gap_nxt   = GAP_W'(1);
              nxt_state = GUARD;
            end
          end
        end
        GUARD: begin
          // Reaching the window end takes priority, so an edge on that cycle is legal
          if (gap_met) begin
            if (edge_det) begin
              cnt_inc = 1'b1;
              if (min_gap == '0) begin
                nxt_state = READY;
              end else begin
                gap_nxt   = GAP_W'(1);
                nxt_state = GUARD;
              end
            end else begin
              gap_nxt   = gap_inc;
              nxt_state = READY;
            end
          end else if (edge_det) begin
            cnt_inc  = 1'b1;
            viol_set = 1'b1;
            gap_nxt  = GAP_W'(1);
          end else begin
            gap_nxt = gap_inc;
          end
        end
        default: nxt_state = FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      gap_q     <= '0;
      pulse_evt <= 1'b0;
      pulse_cnt <= '0;
      viol      <= 1'b0;
      viol_cnt  <= '0;
      unknown   <= 1'b0;
    end else begin
      pulse_evt <= edge_det && (cur_state != FAULT);
      if (cnt_clr) begin
        cur_state <= IDLE;
        gap_q     <= '0;
        pulse_cnt <= '0;
        viol      <= 1'b0;
        viol_cnt  <= '0;
        unknown   <= 1'b0;
      end else begin
        cur_state <= nxt_state;
        gap_q     <= gap_nxt;
        if (cnt_inc && (pulse_cnt != '1)) pulse_cnt <= pulse_cnt + 1'b1;
        if (viol_set && (viol_cnt != '1)) viol_cnt <= viol_cnt + 1'b1;
        if (viol_set) viol <= 1'b1;
        if (in_unknown) unknown <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sfq_pulse_monitor.sv
// tb/tb_sfq_pulse_monitor.sv - directed table-driven bench for sfq_pulse_monitor
module tb_sfq_pulse_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pulse_in;
  logic        cnt_clr;
  logic [7:0]  min_gap;
  logic        pulse_evt;
  logic [15:0] pulse_cnt;
  logic        viol;
  logic [15:0] viol_cnt;
  logic        unknown;
  logic [1:0]  state;

  logic        sat_in;
  logic        sat_clr;
  logic [7:0]  sat_mg;
  logic        sat_evt;
  logic [1:0]  sat_cnt;
  logic        sat_viol;
  logic [1:0]  sat_vcnt;
  logic        sat_unk;
  logic [1:0]  sat_state;

  logic        line;
  logic        line2;
  logic        xprobe;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  sfq_pulse_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .cnt_clr(cnt_clr), .min_gap(min_gap),
    .pulse_evt(pulse_evt), .pulse_cnt(pulse_cnt), .viol(viol), .viol_cnt(viol_cnt),
    .unknown(unknown), .state(state)
  );

  sfq_pulse_monitor #(.SYNC_STAGES(2), .CNT_W(2), .GAP_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .pulse_in(sat_in), .cnt_clr(sat_clr), .min_gap(sat_mg),
    .pulse_evt(sat_evt), .pulse_cnt(sat_cnt), .viol(sat_viol), .viol_cnt(sat_vcnt),
    .unknown(sat_unk), .state(sat_state)
  );

  typedef struct {
    bit       rst_n;
    bit       tog;
    bit       clr;
    bit [7:0] mg;
    int       n;
    bit       e_evt;
    int       e_cnt;
    bit       e_viol;
    int       e_vcnt;
    int       e_st;
    bit       e_unk;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit t, bit c, bit [7:0] mg, int n,
                              bit ev, int cn, bit vi, int vc, int st, bit un);
    vec_t v;
    v.rst_n = r; v.tog = t; v.clr = c; v.mg = mg; v.n = n;
    v.e_evt = ev; v.e_cnt = cn; v.e_viol = vi; v.e_vcnt = vc; v.e_st = st; v.e_unk = un;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_main(string tag, bit ev, int cn, bit vi, int vc, int st, bit un);
    chk({tag, ".evt"},   32'(pulse_evt), 32'(ev));
    chk({tag, ".cnt"},   32'(pulse_cnt), 32'(cn));
    chk({tag, ".viol"},  32'(viol),      32'(vi));
    chk({tag, ".vcnt"},  32'(viol_cnt),  32'(vc));
    chk({tag, ".state"}, 32'(state),     32'(st));
    chk({tag, ".unk"},   32'(unknown),   32'(un));
  endtask

  task automatic cyc(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; cnt_clr = 1'b0; min_gap = 8'd4; line = 1'b0; pulse_in = 1'b0;
    line2 = 1'b0; sat_in = 1'b0; sat_clr = 1'b0; sat_mg = 8'd8;

    //  rst tog clr mg  n   evt cnt viol vcnt st unk
    add(0, 0, 0, 4, 2,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4, 1,  0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 4, 1,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4, 1,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4, 1,  1, 1, 0, 0, 1, 0);
    add(1, 0, 0, 4, 1,  0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 4, 2,  0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 4, 1,  0, 1, 0, 0, 2, 0);
    add(1, 0, 0, 4, 3,  0, 1, 0, 0, 2, 0);
    add(1, 1, 0, 4, 2,  0, 1, 0, 0, 2, 0);
    add(1, 0, 0, 4, 1,  1, 2, 0, 0, 1, 0);
    add(1, 0, 0, 4, 7,  0, 2, 0, 0, 2, 0);
    add(1, 1, 0, 4, 3,  1, 3, 0, 0, 1, 0);
    add(1, 0, 0, 4, 1,  0, 3, 0, 0, 1, 0);
    add(1, 1, 0, 4, 3,  1, 4, 0, 0, 1, 0);
    add(1, 1, 0, 4, 3,  1, 5, 1, 1, 1, 0);
    add(1, 0, 0, 4, 3,  0, 5, 1, 1, 1, 0);
    add(1, 0, 0, 4, 1,  0, 5, 1, 1, 2, 0);
    add(1, 0, 1, 4, 1,  0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 4, 2,  0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 4, 1,  1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4, 1,  0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 5, 2,  0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 5, 1,  1, 1, 0, 0, 1, 0);
    add(1, 0, 0, 5, 1,  0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 5, 1,  1, 2, 1, 1, 1, 0);
    add(1, 0, 0, 2, 1,  0, 2, 1, 1, 1, 0);
    add(1, 0, 0, 2, 1,  0, 2, 1, 1, 2, 0);
    add(1, 1, 0, 0, 3,  1, 3, 1, 1, 2, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; cnt_clr = tbl[i].clr; min_gap = tbl[i].mg;
      if (tbl[i].tog) begin line = ~line; pulse_in = line; end
      cyc(tbl[i].n);
      chk_main($sformatf("row%0d", i), tbl[i].e_evt, tbl[i].e_cnt, tbl[i].e_viol,
               tbl[i].e_vcnt, tbl[i].e_st, tbl[i].e_unk);
    end
    cnt_clr = 1'b0;

    // reset while in GUARD with a toggle sitting in the synchronizer
    min_gap = 8'd8;
    line = ~line; pulse_in = line;
    cyc(3);
    chk("rst.pre_state", 32'(state), 32'd1);
    line = ~line; pulse_in = line;
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    chk_main("rst.in", 0, 0, 0, 0, 0, 0);
    line = 1'b0; pulse_in = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk($sformatf("rst.post%0d.evt", k), 32'(pulse_evt), 32'd0);
    end
    chk_main("rst.post", 0, 0, 0, 0, 0, 0);

    // saturation on the 2-bit counter instance; every pair is 3 clks apart, below its gap of 8
    for (int k = 1; k <= 5; k++) begin
      line2 = ~line2; sat_in = line2;
      cyc(3);
      chk($sformatf("sat%0d.cnt", k),  32'(sat_cnt),  32'((k > 3) ? 3 : k));
      chk($sformatf("sat%0d.vcnt", k), 32'(sat_vcnt), 32'((k - 1 > 3) ? 3 : k - 1));
    end
    chk("sat.viol", 32'(sat_viol), 32'd1);

    // X on the line is only representable in a four-state simulator
    xprobe = 1'bx;
    if ($isunknown(xprobe)) begin
      min_gap = 8'd0;
      line = ~line; pulse_in = line;
      cyc(4);
      chk("flt.pre_cnt", 32'(pulse_cnt), 32'd1);
      pulse_in = 1'bx;
      cyc(1);
      pulse_in = line;
      chk("flt.unk", 32'(unknown), 32'd1);
      chk("flt.state", 32'(state), 32'd3);
      line = ~line; pulse_in = line;
      cyc(3);
      line = ~line; pulse_in = line;
      cyc(5);
      chk("flt.frozen_cnt", 32'(pulse_cnt), 32'd1);
      chk("flt.hold_state", 32'(state), 32'd3);
      cnt_clr = 1'b1;
      cyc(1);
      cnt_clr = 1'b0;
      chk_main("flt.clr", 0, 0, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
